// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot loader block.
package boot_loader_pkg;

    localparam int DEF_ADDR_W     = 11;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS      = 2 ** DEF_ADDR_W;
    // 16-bit frame word count plus one bit so 2**ADDR_W compares cleanly
    localparam int LEN_W          = 17;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Largest legal word count for a RAM with the given address width
    function automatic logic [LEN_W-1:0] max_words(input int aw);
        return LEN_W'(1) << aw;
    endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Byte stream in, RAM port B out, plus CPU reset and status flags.
interface boot_loader_if
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = WORD_W
);
    logic [ADDR_W-1:0] load_base;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              ram_w_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    // The loader itself
    modport slave (
        input  load_base, byte_in, byte_valid,
        output byte_ready, ram_w_en, ram_addr, ram_wdata,
        output cpu_rst_n, busy, done, err
    );

    // Stream source / system side
    modport master (
        output load_base, byte_in, byte_valid,
        input  byte_ready, ram_w_en, ram_addr, ram_wdata,
        input  cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/boot_loader_word_packer.sv
// Packs bytes little-endian into a 32-bit word; o_full flags the push
// that completes the word.
module word_packer
    import boot_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic              i_clear,
    input  logic [7:0]        i_byte,
    output logic [WORD_W-1:0] o_word,
    output logic              o_full
);
    logic [1:0] r_lane;

    assign o_full = i_push && (r_lane == 2'(BYTES_PER_WORD - 1));

    // Lane counter: next byte position inside the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane <= 2'd0;
        end else if (i_clear) begin
            r_lane <= 2'd0;
        end else if (i_push) begin
            r_lane <= r_lane + 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
            logic [7:0] r_byte;

            // Capture the incoming byte when it targets this lane
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_byte <= 8'd0;
                end else if (i_clear) begin
                    r_byte <= 8'd0;
                end else if (i_push && (r_lane == 2'(gi))) begin
                    r_byte <= i_byte;
                end
            end

            assign o_word[gi*8 +: 8] = r_byte;
        end
    endgenerate

endmodule

// File: rtl/boot_loader.sv
// Frame loader: length, payload packed into RAM words, XOR checksum,
// then CPU release. Terminal DONE/ERR until rst_n.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = WORD_W
)(
    input  logic          clk,
    input  logic          rst_n,
    boot_loader_if.slave  bus
);
    localparam logic [LEN_W-1:0] MAX_N = max_words(ADDR_W);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len_lo;
    logic [7:0]        r_csum;
    logic [LEN_W-1:0]  r_words;
    logic [LEN_W-1:0]  r_widx;
    logic              r_ram_w_en;
    logic              r_cpu_rst_n;
    logic              r_done;
    logic              r_err;

    logic              w_byte_ready;
    logic              w_busy;
    logic              w_accept;
    logic              w_push;
    logic              w_clear;
    logic              w_full;
    logic [DATA_W-1:0] w_word;
    logic [LEN_W-1:0]  w_len;

    assign w_byte_ready = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                          (r_state == DATA)   || (r_state == CSUM);
    assign w_busy       = w_byte_ready || (r_state == WRITE);
    assign w_accept     = bus.byte_valid && w_byte_ready;
    assign w_push       = w_accept && (r_state == DATA);
    // Partial words never survive a WRITE or a restart
    assign w_clear      = (r_state == IDLE) || (r_state == WRITE);
    assign w_len        = {1'b0, bus.byte_in, r_len_lo};

    word_packer u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_clear (w_clear),
        .i_byte  (bus.byte_in),
        .o_word  (w_word),
        .o_full  (w_full)
    );

    // Frame FSM with registered RAM strobe, CPU reset and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_len_lo    <= 8'd0;
            r_csum      <= 8'd0;
            r_words     <= '0;
            r_widx      <= '0;
            r_ram_w_en  <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ram_w_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_addr  <= bus.load_base;
                    r_widx  <= '0;
                    r_csum  <= 8'd0;
                    r_state <= LEN_LO;
                end
                LEN_LO: if (w_accept) begin
                    r_len_lo <= bus.byte_in;
                    r_state  <= LEN_HI;
                end
                LEN_HI: if (w_accept) begin
                    r_words <= w_len;
                    if (w_len > MAX_N)       r_state <= ERR;
                    else if (w_len == '0)    r_state <= CSUM;
                    else                     r_state <= DATA;
                end
                DATA: if (w_accept) begin
                    r_csum <= r_csum ^ bus.byte_in;
                    // Strobe goes out together with the completed word
                    if (w_full) begin
                        r_ram_w_en <= 1'b1;
                        r_state    <= WRITE;
                    end
                end
                WRITE: begin
                    r_addr <= r_addr + 1'b1;
                    r_widx <= r_widx + 1'b1;
                    if (r_widx == r_words - 1'b1) r_state <= CSUM;
                    else                          r_state <= DATA;
                end
                CSUM: if (w_accept) begin
                    r_state <= (bus.byte_in == r_csum) ? DONE : ERR;
                end
                DONE: begin
                    r_done      <= 1'b1;
                    r_cpu_rst_n <= 1'b1;
                end
                ERR: begin
                    r_err       <= 1'b1;
                    r_cpu_rst_n <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.busy       = w_busy;
    assign bus.ram_w_en   = r_ram_w_en;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_wdata  = w_word;
    assign bus.cpu_rst_n  = r_cpu_rst_n;
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized frame bench for boot_loader against a frame-level model.
module tb_boot_loader;
    import boot_loader_pkg::*;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    boot_loader_if #(.ADDR_W(AW), .DATA_W(32)) bus ();

    boot_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    // Captured RAM writes {addr, data}; only this block writes them
    logic [42:0] got_q[$];
    int          wen_double = 0;
    logic        prev_wen   = 1'b0;

    always @(negedge clk) begin
        if (bus.ram_w_en) begin
            got_q.push_back({bus.ram_addr, bus.ram_wdata});
            if (prev_wen) wen_double++;
        end
        prev_wen = bus.ram_w_en;
    end

    logic [7:0] pl_q[$];

    task automatic do_reset();
        bus.byte_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", bus.byte_ready, 0);
        check("rst_wen",   bus.ram_w_en, 0);
        check("rst_addr",  bus.ram_addr, 0);
        check("rst_wdata", bus.ram_wdata, 0);
        check("rst_cpu",   bus.cpu_rst_n, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_err",   bus.err, 0);
        rst_n = 1'b1;
    endtask

    // Present one byte and return at the negedge after it was taken
    task automatic send_byte(input logic [7:0] b, input bit held);
        int cnt;
        cnt = 0;
        if (!held && $urandom_range(0, 3) == 0) begin
            bus.byte_valid = 1'b0;
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!bus.byte_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 100) begin
            check("ready_timeout", 1, 0);
            bus.byte_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!held) bus.byte_valid = 1'b0;
    endtask

    // csum_in < 0 sends the correct checksum, otherwise that exact byte
    task automatic run_frame(input logic [AW-1:0] base, input int n, input int csum_in,
                             input bit held, input bit do_rst);
        logic [7:0]  xsum;
        logic [7:0]  sent;
        logic [15:0] n16;
        logic [42:0] exp_q[$];
        int          wr0;
        int          dbl0;
        bit          good;
        bus.load_base = base;
        if (do_rst) do_reset();
        wr0  = got_q.size();
        dbl0 = wen_double;
        n16  = 16'(n);
        if (n <= MAX_WORDS && pl_q.size() != 4 * n) begin
            pl_q.delete();
            for (int k = 0; k < 4 * n; k++) pl_q.push_back(8'($urandom));
        end
        xsum = 8'd0;
        if (n <= MAX_WORDS) begin
            foreach (pl_q[k]) xsum ^= pl_q[k];
            for (int i = 0; i < n; i++)
                exp_q.push_back({AW'(int'(base) + i),
                                 pl_q[4*i+3], pl_q[4*i+2], pl_q[4*i+1], pl_q[4*i]});
        end
        sent = (csum_in < 0) ? xsum : 8'(csum_in);
        good = (sent == xsum);
        $display("frame base=0x%03h n=%0d csum=0x%02h model=0x%02h held=%0d", base, n, sent, xsum, held);

        send_byte(n16[7:0], held);
        check("busy_len", bus.busy, 1);
        send_byte(n16[15:8], held);
        if (n > MAX_WORDS) begin
            bus.byte_valid = 1'b1;
            repeat (4) begin
                @(negedge clk);
                check("ovf_ready", bus.byte_ready, 0);
            end
            check("ovf_err",    bus.err, 1);
            check("ovf_done",   bus.done, 0);
            check("ovf_cpu",    bus.cpu_rst_n, 0);
            check("ovf_writes", got_q.size() - wr0, 0);
            bus.byte_valid = 1'b0;
            pl_q.delete();
            return;
        end
        for (int k = 0; k < 4 * n; k++) begin
            send_byte(pl_q[k], held);
            if (k % 4 == 3) check("wen_lat", bus.ram_w_en, 1);
            else            check("wen_idle", bus.ram_w_en, 0);
        end
        send_byte(sent, held);
        check("cpu_early",  bus.cpu_rst_n, 0);
        check("done_early", bus.done, 0);
        @(negedge clk);
        check("done",  bus.done, good);
        check("err",   bus.err, !good);
        check("cpu",   bus.cpu_rst_n, good);
        check("busy_end",  bus.busy, 0);
        check("ready_end", bus.byte_ready, 0);
        bus.byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("cpu_stable", bus.cpu_rst_n, good);
        check("nwrites", got_q.size() - wr0, exp_q.size());
        for (int i = 0; i < exp_q.size() && wr0 + i < got_q.size(); i++)
            check("word", got_q[wr0 + i], exp_q[i]);
        check("wen_width", wen_double - dbl0, 0);
        pl_q.delete();
    endtask

    // Reset in the middle of a word, then load a fresh frame without a second reset
    task automatic midload_reset();
        int wr0;
        bus.load_base = 11'h123;
        do_reset();
        wr0 = got_q.size();
        send_byte(8'd2, 1'b1);
        send_byte(8'd0, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(8'($urandom), 1'b1);
        rst_n = 1'b0;
        bus.byte_valid = 1'b0;
        #1;
        check("mid_cpu",   bus.cpu_rst_n, 0);
        check("mid_busy",  bus.busy, 0);
        check("mid_ready", bus.byte_ready, 0);
        check("mid_wen",   bus.ram_w_en, 0);
        repeat (3) @(negedge clk);
        check("mid_writes", got_q.size() - wr0, 0);
        rst_n = 1'b1;
        run_frame(11'h456, 3, -1, 1'b1, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.load_base  = '0;
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        @(negedge clk);

        // Known frame; XOR of 11..44 AA..DD is 0x44
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame(11'h010, 2, -1, 1'b0, 1'b1);
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame(11'h010, 2, 8'h01, 1'b0, 1'b1);
        run_frame(11'h200, 0, 8'h00, 1'b0, 1'b1);
        run_frame(11'h000, 2049, -1, 1'b0, 1'b1);
        run_frame(11'h7FF, 2, -1, 1'b0, 1'b1);
        run_frame(AW'($urandom), 6, -1, 1'b1, 1'b1);
        midload_reset();

        for (int t = 0; t < 10; t++) begin
            int cs;
            cs = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 255)) : -1;
            run_frame(AW'($urandom), $urandom_range(0, 6), cs, 1'($urandom_range(0, 1)), 1'b1);
        end

        run_frame(AW'($urandom), MAX_WORDS, -1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
